linebuf_core: RTL and testbench
===============================

LINEBUF_CORE -- requirements
Module: linebuf_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, width of data_in/data_out.
REQ-002 SHALL have parameter DEPTH, 1024, maximum buffer depth in words (power of two, 16..4096).
REQ-003 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  when low, freezes all datapath state; config writes still accepted.
REQ-006 SHALL have port flush  input  1  synchronous clear of pointers/count; config retained.
REQ-007 SHALL have port config_en  input  1  config write strobe.
REQ-008 SHALL have port config_addr  input  32  config register select; only address 0 is decoded.
REQ-009 SHALL have port config_data  input  32  config write data.
REQ-010 SHALL have port read_config_data  output  32  current config register, zero-extended.
REQ-011 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-012 SHALL have port wen_in  input  1  write request.
REQ-013 SHALL have port ren_in  input  1  read request, FIFO mode only.
REQ-014 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-015 SHALL have port valid_out  output  1  data_out valid this cycle.
REQ-016 SHALL have port full  output  1  count == depth.
REQ-017 SHALL have port empty  output  1  count == 0.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Config word SHALL be: [1:0] mode (0 line buffer, 1 FIFO, 2/3 reserved = disabled), [2] enable, [15:3] depth; written when config_en=1 and config_addr=0, independent of clk_en.
REQ-020 Effective depth SHALL be min(config depth, DEPTH); depth 0, enable=0 or reserved mode SHALL disable the block (no writes, valid_out=0).
REQ-021 A config write SHALL also clear pointers and count in the same edge.
REQ-022 Storage SHALL be a circular buffer with write/read pointers wrapping at effective depth, not at DEPTH.
REQ-023 Line-buffer mode: write accepted on every wen_in=1 cycle; ren_in ignored.
REQ-024 Line-buffer mode: while count < depth, a write SHALL increment count and produce no output.
REQ-025 Line-buffer mode: a write with count == depth SHALL pop the oldest word and push data_in in the same cycle; count stays at depth; popped word on data_out with valid_out=1 on the next cycle (latency 1).
REQ-026 FIFO mode: write accepted iff wen_in=1 and (not full or ren_in=1); read accepted iff ren_in=1 and not empty.
REQ-027 FIFO mode: simultaneous accepted read and write SHALL leave count unchanged; write to empty with read SHALL not bypass (read ignored, count becomes 1).
REQ-028 FIFO mode: accepted read SHALL present word on data_out with valid_out=1 the following cycle.
REQ-029 valid_out SHALL be 1 for exactly one cycle per pop; data_out SHALL hold its last value otherwise.
REQ-030 clk_en=0 SHALL block writes, reads, pointer/count updates, and force valid_out=0 the next cycle.
REQ-031 flush=1 (with clk_en=1) SHALL clear pointers and count, suppress any same-cycle read/write, and force valid_out=0 the next cycle; flush has priority over wen_in/ren_in.
REQ-032 full and empty SHALL be combinational from count and effective depth.

Reset
REQ-033 reset=1 SHALL asynchronously set config register to 0, pointers/count to 0, data_out to 0, valid_out to 0; hence empty=1, full=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored data; memory contents need not be cleared.
REQ-035 After reset deassertion the block SHALL stay disabled until configured.

Verification
REQ-036 LB depth 15, wen_in=1 every cycle, data_in 1,2,3,... -> no valid for first 15 writes; 16th write -> next cycle data_out=1 valid_out=1; then 2,3,... each cycle.
REQ-037 LB depth 15 after 40 writes, flush for 5 cycles, restart writes -> valid_out=0 during flush+15 writes, first output is first post-flush word.
REQ-038 FIFO depth 4: write 10,11,12,13 -> full=1; extra write ignored; 4 reads -> data_out 10..13, then empty=1, further read gives valid_out=0.
REQ-039 FIFO full with wen_in=ren_in=1 -> pops oldest, pushes new, count stays 4.
REQ-040 clk_en=0 for 5 cycles mid-stream -> count, pointers frozen, valid_out=0; resumes with no data loss or duplication.
REQ-041 Config depth 5000 with DEPTH=1024 -> effective depth 1024; reset asserted mid-stream -> read_config_data=0, valid_out=0 immediately.

Source files
------------

// File: rtl/linebuf_core.sv
// linebuf_core: configurable circular buffer acting as a fixed-delay line buffer or a FIFO.
// The effective depth comes from a 16-bit config word, capped at DEPTH.
module linebuf_core #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic                    config_en,
    input  logic [31:0]             config_addr,
    input  logic [31:0]             config_data,
    output logic [31:0]             read_config_data,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    wen_in,
    input  logic                    ren_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [12:0] DMAX = 13'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [15:0]   cfg;
    logic [AW-1:0] wptr, rptr, wnext, rnext;
    logic [CW-1:0] eff, winc, rinc;
    logic          enabled, lb, cfg_we, go, wr, rd;
    logic          unused_cfg;

    assign unused_cfg       = ^config_data[31:16];
    assign read_config_data = {16'b0, cfg};
    assign eff              = (cfg[15:3] > DMAX) ? CW'(DEPTH) : cfg[CW+2:3];
    assign enabled          = cfg[2] && (cfg[1:0] < 2'd2) && (eff != '0);
    assign lb               = (cfg[1:0] == 2'd0);
    assign full             = enabled && (count == eff);
    assign empty            = (count == '0);
    assign cfg_we           = config_en && (config_addr == 32'd0);
    assign go               = clk_en && !flush && !cfg_we && enabled;
    assign wr               = go && wen_in && (lb || !full || ren_in);
    assign rd               = lb ? (wr && full) : (go && ren_in && !empty);
    // Pointers wrap at the configured depth, not at the physical size.
    assign winc             = {1'b0, wptr} + 1'b1;
    assign rinc             = {1'b0, rptr} + 1'b1;
    assign wnext            = (winc == eff) ? '0 : winc[AW-1:0];
    assign rnext            = (rinc == eff) ? '0 : rinc[AW-1:0];

    always_ff @(posedge clk_in) begin
        if (wr) mem[wptr] <= data_in;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cfg       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (cfg_we) cfg <= config_data[15:0];
            valid_out <= rd;
            if (rd) data_out <= mem[rptr];
            if (cfg_we || (clk_en && flush)) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr) wptr <= wnext;
                if (rd) rptr <= rnext;
                if (wr != rd) count <= wr ? count + 1'b1 : count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_linebuf_core.sv
// tb_linebuf_core: directed stimulus with a queue-based reference model checked every cycle.
module tb_linebuf_core;
    localparam int DW = 16;
    localparam int DEPTH = 1024;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          clk_en = 1'b1;
    logic          flush = 1'b0;
    logic          config_en = 1'b0;
    logic [31:0]   config_addr = '0;
    logic [31:0]   config_data = '0;
    logic [31:0]   read_config_data;
    logic [DW-1:0] data_in = '0;
    logic          wen_in = 1'b0;
    logic          ren_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    linebuf_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .reset(reset), .clk_en(clk_en), .flush(flush),
        .config_en(config_en), .config_addr(config_addr), .config_data(config_data),
        .read_config_data(read_config_data), .data_in(data_in), .wen_in(wen_in),
        .ren_in(ren_in), .data_out(data_out), .valid_out(valid_out), .full(full),
        .empty(empty), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue holding the buffered words in arrival order.
    int          q[$];
    logic [15:0] mcfg = '0;
    logic        exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;

    function automatic int mdepth();
        return (int'(mcfg[15:3]) > DEPTH) ? DEPTH : int'(mcfg[15:3]);
    endfunction

    function automatic bit menabled();
        return mcfg[2] && mcfg[1:0] < 2 && mdepth() > 0;
    endfunction

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            q.delete();
            mcfg = '0;
            exp_valid = 1'b0;
            exp_data = '0;
        end else begin
            exp_valid = 1'b0;
            if (config_en && config_addr == 0) begin
                mcfg = config_data[15:0];
                q.delete();
            end else if (clk_en) begin
                if (flush) q.delete();
                else if (menabled()) begin
                    if (mcfg[1:0] == 0) begin
                        if (wen_in) begin
                            if (q.size() == mdepth()) begin
                                exp_data = DW'(q.pop_front());
                                exp_valid = 1'b1;
                            end
                            q.push_back(int'(data_in));
                        end
                    end else begin
                        automatic bit was_full = q.size() == mdepth();
                        automatic bit do_rd = ren_in && q.size() > 0;
                        automatic bit do_wr = wen_in && (!was_full || ren_in);
                        if (do_rd) begin
                            exp_data = DW'(q.pop_front());
                            exp_valid = 1'b1;
                        end
                        if (do_wr) q.push_back(int'(data_in));
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(menabled() && q.size() == mdepth()));
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("read_config_data", read_config_data, {16'b0, mcfg});
    end

    task automatic cyc(input logic w, input logic r, input int d);
        wen_in = w;
        ren_in = r;
        data_in = DW'(d);
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(input int mode, input int en, input int depth);
        config_en = 1'b1;
        config_addr = 0;
        config_data = 32'((depth << 3) | (en << 2) | mode);
        cyc(0, 0, 0);
        config_en = 1'b0;
    endtask

    initial begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset cfg", read_config_data, 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 77);
        chk("disabled count", 32'(count), 32'd0);

        // Line buffer, depth 15
        cfg_write(0, 1, 15);
        for (int i = 1; i <= 15; i++) cyc(1, 0, i);
        chk("lb no early valid", 32'(valid_out), 32'd0);
        cyc(1, 0, 16);
        chk("lb first out", 32'(data_out), 32'd1);
        chk("lb first valid", 32'(valid_out), 32'd1);
        cyc(1, 0, 17);
        chk("lb second out", 32'(data_out), 32'd2);
        for (int i = 18; i <= 25; i++) cyc(1, 0, i);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 0, 500 + i);
        chk("clk_en frozen valid", 32'(valid_out), 32'd0);
        clk_en = 1'b1;
        cyc(1, 0, 26);
        chk("clk_en resume", 32'(data_out), 32'd11);
        for (int i = 27; i <= 40; i++) cyc(1, 0, i);
        flush = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1, 1, 999);
        flush = 1'b0;
        chk("flush count", 32'(count), 32'd0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 100 + i);
        cyc(1, 0, 115);
        chk("post flush first", 32'(data_out), 32'd100);

        // Ignored address, then FIFO depth 4
        config_en = 1'b1; config_addr = 1; config_data = 32'h0000_FFFF;
        cyc(0, 0, 0);
        config_en = 1'b0;
        cfg_write(1, 1, 4);
        for (int i = 10; i <= 13; i++) cyc(1, 0, i);
        chk("fifo full", 32'(full), 32'd1);
        cyc(1, 0, 14);
        chk("fifo extra write", 32'(count), 32'd4);
        for (int i = 10; i <= 13; i++) begin
            cyc(0, 1, 0);
            chk("fifo read", 32'(data_out), 32'(i));
        end
        chk("fifo empty", 32'(empty), 32'd1);
        cyc(0, 1, 0);
        chk("fifo empty read", 32'(valid_out), 32'd0);
        cyc(1, 1, 20);
        chk("fifo no bypass", 32'(count), 32'd1);
        for (int i = 21; i <= 23; i++) cyc(1, 0, i);
        cyc(1, 1, 24);
        chk("fifo full rw out", 32'(data_out), 32'd20);
        chk("fifo full rw count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        clk_en = 1'b0;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        clk_en = 1'b1;
        cyc(0, 1, 0);
        cyc(0, 1, 0);

        // Reserved mode disables the block
        cfg_write(2, 1, 4);
        for (int i = 0; i < 3; i++) cyc(1, 1, 5);
        chk("reserved count", 32'(count), 32'd0);

        // Depth capped at DEPTH
        cfg_write(0, 1, 5000);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, i);
        chk("cap full", 32'(full), 32'd1);
        cyc(1, 0, 3000);
        chk("cap first out", 32'(data_out), 32'd1);
        cyc(1, 0, 3001);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset cfg", read_config_data, 32'd0);
        chk("async reset valid", 32'(valid_out), 32'd0);
        chk("async reset count", 32'(count), 32'd0);
        cyc(0, 0, 0);
        reset = 1'b0;
        cyc(1, 0, 1);
        cyc(1, 0, 2);
        chk("post reset disabled", 32'(count), 32'd0);
        @(negedge clk_in);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
